// File: rtl/max7219_display_driver.sv
// MAX7219 3-wire SPI driver: auto-configures the chip, then refreshes 1..8 BCD digits from a per-frame snapshot.
// Latency: word = 34*SCLK_DIV clocks (32 CS-low + 2 CS-high); INIT = 5 words, frame = 2+NUM_DIGITS words.
// Backpressure: none; ena is only sampled in IDLE and at frame end, and busy marks INIT/frame activity.
module max7219_display_driver #(
    parameter int NUM_DIGITS = 6,
    parameter int SCLK_DIV   = 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    ena,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [3:0]              intensity,
    input  logic                    blank,
    output logic                    MOSI,
    output logic                    CS,
    output logic                    clk_SPI,
    output logic                    busy
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DW-1:0] DMAX        = DW'(SCLK_DIV - 1);
    localparam logic [7:0]    DECODE_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);
    localparam logic [7:0]    SCAN_LIMIT  = 8'(NUM_DIGITS - 1);
    localparam logic [3:0]    INIT_LAST   = 4'd4;
    localparam logic [3:0]    FRAME_LAST  = 4'(NUM_DIGITS + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FRAME} state_t;

    state_t                  state;
    logic                    in_word;
    logic [3:0]              word_idx;
    logic [5:0]              half_idx;
    logic [DW-1:0]           div_cnt;
    logic [15:0]             shreg;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [3:0]              snap_intensity;
    logic                    snap_blank;

    logic        word_end;
    logic        last_word;
    logic        frame_restart;
    logic        go_idle;
    logic        start_word;
    logic [15:0] load_word;

    function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] inten,
                                              input logic blk);
        logic [15:0] w;
        case (idx)
            4'd0:    w = {8'h09, DECODE_MASK};
            4'd1:    w = {8'h0B, SCAN_LIMIT};
            4'd2:    w = 16'h0F00;
            4'd3:    w = {8'h0A, 4'h0, inten};
            default: w = {8'h0C, 7'h00, ~blk};
        endcase
        return w;
    endfunction

    function automatic logic [15:0] frame_word(input logic [3:0] idx, input logic [3:0] inten,
                                               input logic blk,
                                               input logic [4*NUM_DIGITS-1:0] dig,
                                               input logic [NUM_DIGITS-1:0] dpv);
        logic [15:0] w;
        logic [31:0] dig32;
        logic [7:0]  dp8;
        logic [2:0]  i;
        dig32 = 32'(dig);
        dp8   = 8'(dpv);
        i     = 3'(idx - 4'd2);
        if (idx == 4'd0)
            w = {8'h0A, 4'h0, inten};
        else if (idx == 4'd1)
            w = {8'h0C, 7'h00, ~blk};
        else
            w = {4'h0, idx - 4'd1, dp8[i], 3'b000, dig32[{i, 2'b00} +: 4]};
        return w;
    endfunction

    assign word_end      = in_word && (div_cnt == DMAX) && (half_idx == 6'd33);
    assign last_word     = (state == ST_INIT) ? (word_idx == INIT_LAST) : (word_idx == FRAME_LAST);
    // A new frame (from IDLE or back-to-back) loads its first word straight from the live inputs,
    // which are the very values captured into the snapshot on the same edge.
    assign frame_restart = ((state == ST_IDLE) && ena) ||
                           ((state == ST_FRAME) && word_end && last_word && ena);
    assign go_idle       = word_end && last_word && ((state == ST_INIT) || !ena);
    assign start_word    = ((state == ST_INIT) && !in_word) || frame_restart ||
                           (word_end && !last_word);

    always_comb begin
        load_word = 16'h0000;
        if (frame_restart)
            load_word = frame_word(4'd0, intensity, blank, digits, dp);
        else if (state == ST_INIT)
            load_word = init_word(in_word ? word_idx + 4'd1 : 4'd0, intensity, blank);
        else
            load_word = frame_word(word_idx + 4'd1, snap_intensity, snap_blank, snap_digits, snap_dp);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state          <= ST_INIT;
            in_word        <= 1'b0;
            word_idx       <= 4'd0;
            half_idx       <= 6'd0;
            div_cnt        <= '0;
            shreg          <= 16'h0000;
            snap_digits    <= '0;
            snap_dp        <= '0;
            snap_intensity <= 4'h0;
            snap_blank     <= 1'b0;
            CS             <= 1'b1;
            clk_SPI        <= 1'b0;
            MOSI           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (start_word) begin
                CS       <= 1'b0;
                clk_SPI  <= 1'b0;
                MOSI     <= load_word[15];
                shreg    <= {load_word[14:0], 1'b0};
                half_idx <= 6'd0;
                div_cnt  <= '0;
                in_word  <= 1'b1;
                busy     <= 1'b1;
                word_idx <= (frame_restart || !in_word) ? 4'd0 : word_idx + 4'd1;
            end else if (go_idle) begin
                state    <= ST_IDLE;
                in_word  <= 1'b0;
                busy     <= 1'b0;
                MOSI     <= 1'b0;
                word_idx <= 4'd0;
            end else if (in_word) begin
                if (div_cnt != DMAX) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    // Half-periods 0..31 carry 16 bits (even = SCLK low, odd = high); 32..33 are the CS-high gap.
                    div_cnt  <= '0;
                    half_idx <= half_idx + 6'd1;
                    if (half_idx == 6'd31) begin
                        clk_SPI <= 1'b0;
                        CS      <= 1'b1;
                    end else if (half_idx < 6'd31) begin
                        if (!half_idx[0]) begin
                            clk_SPI <= 1'b1;
                        end else begin
                            clk_SPI <= 1'b0;
                            MOSI    <= shreg[15];
                            shreg   <= {shreg[14:0], 1'b0};
                        end
                    end
                end
            end

            if (frame_restart) begin
                state          <= ST_FRAME;
                snap_digits    <= digits;
                snap_dp        <= dp;
                snap_intensity <= intensity;
                snap_blank     <= blank;
            end
        end
    end

endmodule

// File: tb/tb_max7219_display_driver.sv
// Bench for max7219_display_driver: a 6-digit/div-1 and a 4-digit/div-3 instance share stimulus;
// an SPI monitor decodes words and timing and a word-list model built from the chip protocol supplies expectations.
module tb_max7219_display_driver;

    localparam int NA = 6, DA = 1, NB = 4, DB = 3;

    logic        clk = 1'b0;
    logic        res, ena, blank;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [3:0]  intensity;
    logic        mosi_a, cs_a, sclk_a, busy_a;
    logic        mosi_b, cs_b, sclk_b, busy_b;

    always #5 clk = ~clk;

    max7219_display_driver #(.NUM_DIGITS(NA), .SCLK_DIV(DA)) dut_a (
        .clk(clk), .res(res), .ena(ena), .digits(digits), .dp(dp), .intensity(intensity),
        .blank(blank), .MOSI(mosi_a), .CS(cs_a), .clk_SPI(sclk_a), .busy(busy_a));

    max7219_display_driver #(.NUM_DIGITS(NB), .SCLK_DIV(DB)) dut_b (
        .clk(clk), .res(res), .ena(ena), .digits(digits[15:0]), .dp(dp[3:0]), .intensity(intensity),
        .blank(blank), .MOSI(mosi_b), .CS(cs_b), .clk_SPI(sclk_b), .busy(busy_b));

    typedef struct {
        logic [15:0] w;
        int          nbits;
        int          low;
        int          gap;
    } rec_t;

    rec_t        qa[$];
    rec_t        qb[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic        p_cs[2]    = '{1'b1, 1'b1};
    logic        p_sclk[2]  = '{1'b0, 1'b0};
    logic        p_mosi[2]  = '{1'b0, 1'b0};
    logic [15:0] sh[2]      = '{16'h0, 16'h0};
    int          nb[2]      = '{0, 0};
    int          low[2]     = '{0, 0};
    int          gap[2]     = '{0, 0};
    int          gap_rec[2] = '{0, 0};
    int          run[2]     = '{0, 0};
    int          viol_clk[2]  = '{0, 0};
    int          viol_mode[2] = '{0, 0};
    int          brun[2]    = '{0, 0};
    int          blen[2]    = '{0, 0};

    // SPI monitor: samples on the falling system clock, away from the edge the DUT updates on.
    always @(negedge clk) begin
        logic c_cs, c_sclk, c_mosi, c_busy;
        rec_t r;
        int   d;
        for (int c = 0; c < 2; c++) begin
            c_cs   = (c == 0) ? cs_a   : cs_b;
            c_sclk = (c == 0) ? sclk_a : sclk_b;
            c_mosi = (c == 0) ? mosi_a : mosi_b;
            c_busy = (c == 0) ? busy_a : busy_b;
            d      = (c == 0) ? DA : DB;
            if (res) begin
                p_cs[c] = 1'b1; p_sclk[c] = 1'b0; p_mosi[c] = 1'b0;
                gap[c] = 0; run[c] = 0; brun[c] = 0;
            end else begin
                if (!c_cs) begin
                    if (p_cs[c]) begin
                        gap_rec[c] = gap[c]; sh[c] = 16'h0; nb[c] = 0; low[c] = 0; run[c] = 1;
                    end else if (c_sclk == p_sclk[c]) begin
                        run[c]++;
                    end else begin
                        if (run[c] != d) viol_clk[c]++;
                        run[c] = 1;
                    end
                    low[c]++;
                    if (c_sclk && !p_sclk[c]) begin
                        sh[c] = {sh[c][14:0], c_mosi};
                        nb[c]++;
                    end
                    if (!p_cs[c] && (c_mosi != p_mosi[c]) && c_sclk) viol_mode[c]++;
                end else begin
                    if (!p_cs[c]) begin
                        r.w = sh[c]; r.nbits = nb[c]; r.low = low[c]; r.gap = gap_rec[c];
                        if (c == 0) qa.push_back(r); else qb.push_back(r);
                        gap[c] = 1;
                    end else begin
                        gap[c]++;
                    end
                end
                if (c_busy) brun[c]++;
                else if (brun[c] != 0) begin
                    blen[c] = brun[c];
                    brun[c] = 0;
                end
                p_cs[c] = c_cs; p_sclk[c] = c_sclk; p_mosi[c] = c_mosi;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_ena();
        ena = 1'b1;
        step(1);
        ena = 1'b0;
    endtask

    task automatic wait_idle(input int c, input int budget, input string tag);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            step(1);
            if ((c == 0) ? busy_a : busy_b) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    function automatic void exp_init(input int n, input logic [3:0] inten, input logic blk);
        exp_q.push_back({8'h09, 8'((1 << n) - 1)});
        exp_q.push_back({8'h0B, 8'(n - 1)});
        exp_q.push_back(16'h0F00);
        exp_q.push_back({8'h0A, 4'h0, inten});
        exp_q.push_back({8'h0C, 7'h00, ~blk});
    endfunction

    function automatic void exp_frame(input int n, input logic [23:0] dig, input logic [5:0] dpv,
                                      input logic [3:0] inten, input logic blk);
        exp_q.push_back({8'h0A, 4'h0, inten});
        exp_q.push_back({8'h0C, 7'h00, ~blk});
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(i + 1), 1'((dpv >> i) & 6'd1), 3'b000, 4'(dig >> (4 * i))});
    endfunction

    task automatic cmp_words(input int c, input string tag);
        rec_t r;
        int   d;
        int   n;
        d = (c == 0) ? DA : DB;
        n = (c == 0) ? qa.size() : qb.size();
        check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            r = (c == 0) ? qa[i] : qb[i];
            check($sformatf("%s_word%0d", tag, i), {16'h0, r.w}, {16'h0, exp_q[i]});
            check($sformatf("%s_shape%0d", tag, i), {r.nbits[15:0], r.low[15:0]},
                  {16'd16, 16'(32 * d)});
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(r.gap), 32'(2 * d));
        end
        if (c == 0) qa.delete(); else qb.delete();
        exp_q.delete();
    endtask

    initial begin
        res = 1'b1; ena = 1'b0; digits = 24'h0; dp = 6'h0; intensity = 4'h8; blank = 1'b0;
        #3;
        check("rst_cs", 32'(cs_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        step(3);
        qa.delete(); qb.delete();
        res = 1'b0;

        wait_idle(0, 400, "init_a");
        check("init_busy_len", 32'(blen[0]), 32'd170);
        exp_init(NA, 4'h8, 1'b0);
        cmp_words(0, "init_a");

        digits = 24'h123456; dp = 6'b000100;
        exp_frame(NA, digits, dp, intensity, blank);
        pulse_ena();
        wait_idle(0, 600, "frame1");
        check("frame1_busy_len", 32'(blen[0]), 32'd272);
        cmp_words(0, "frame1");
        step(30);
        check("idle_cs", 32'(cs_a), 32'd1);
        check("idle_no_words", 32'(qa.size()), 32'd0);

        // Back-to-back frames; inputs change during the third word of the first one.
        exp_frame(NA, digits, dp, intensity, blank);
        ena = 1'b1;
        step(80);
        digits = 24'h000000; dp = 6'h00;
        exp_frame(NA, digits, dp, intensity, blank);
        step(250);
        ena = 1'b0;
        wait_idle(0, 800, "b2b");
        check("b2b_busy_len", 32'(blen[0]), 32'd544);
        cmp_words(0, "b2b");

        blank = 1'b1;
        exp_frame(NA, digits, dp, intensity, blank);
        pulse_ena();
        wait_idle(0, 600, "blank1");
        cmp_words(0, "blank1");
        blank = 1'b0;
        exp_frame(NA, digits, dp, intensity, blank);
        pulse_ena();
        wait_idle(0, 600, "blank0");
        cmp_words(0, "blank0");

        for (int it = 0; it < 6; it++) begin
            digits = 24'($urandom); dp = 6'($urandom); intensity = 4'($urandom); blank = 1'($urandom);
            exp_frame(NA, digits, dp, intensity, blank);
            pulse_ena();
            step($urandom_range(1, 200));
            digits = 24'($urandom); dp = 6'($urandom); intensity = 4'($urandom); blank = 1'($urandom);
            wait_idle(0, 600, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_busy_len", it), 32'(blen[0]), 32'd272);
            cmp_words(0, $sformatf("rnd%0d", it));
        end

        // Reset while bit 7 of the first digit word is on the wire.
        digits = 24'h987654;
        pulse_ena();
        step(83);
        check("mid_cs_low", 32'(cs_a), 32'd0);
        check("mid_sclk_high", 32'(sclk_a), 32'd1);
        #1 res = 1'b1;
        #1;
        check("async_cs", 32'(cs_a), 32'd1);
        check("async_sclk", 32'(sclk_a), 32'd0);
        check("async_mosi", 32'(mosi_a), 32'd0);
        check("async_busy", 32'(busy_a), 32'd0);
        step(2);
        qa.delete(); qb.delete();
        res = 1'b0;
        wait_idle(0, 400, "reinit_a");
        exp_init(NA, intensity, blank);
        cmp_words(0, "reinit_a");

        wait_idle(1, 800, "init_b");
        check("init_b_busy_len", 32'(blen[1]), 32'd510);
        exp_init(NB, intensity, blank);
        cmp_words(1, "init_b");
        digits = 24'($urandom); dp = 6'($urandom); intensity = 4'($urandom); blank = 1'($urandom);
        exp_frame(NB, digits, dp, intensity, blank);
        qa.delete();
        pulse_ena();
        wait_idle(1, 1000, "frame_b");
        check("frame_b_busy_len", 32'(blen[1]), 32'd612);
        cmp_words(1, "frame_b");

        check("sclk_run_a", 32'(viol_clk[0]), 32'd0);
        check("sclk_run_b", 32'(viol_clk[1]), 32'd0);
        check("mode0_a", 32'(viol_mode[0]), 32'd0);
        check("mode0_b", 32'(viol_mode[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max7219_display_driver.md
Name: max7219_display_driver

Overview:
Parametrised successor to the fixed six-digit stopwatch SPI driver. It drives a MAX7219 over a 3-wire SPI link for 1..8 BCD digits, with per-digit decimal points, runtime intensity and blanking. After reset it runs the chip configuration sequence automatically, then refreshes all digits continuously while enabled. Each frame works from a coherent snapshot of the digit inputs. It sits between the counter chain and the uo_out pins.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8.
SCLK_DIV, 1, system clocks per half clk_SPI period; must be ≥1.

Ports:
clk  input  1  system clock
res  input  1  asynchronous reset, active-high
ena  input  1  refresh enable; sampled in IDLE and at end of frame
digits  input  4*NUM_DIGITS  BCD values; digit i in [4i+3:4i], sent to MAX7219 digit register i+1
dp  input  NUM_DIGITS  decimal point per digit; dp[i] goes with digit i
intensity  input  4  brightness value for register 0x0A
blank  input  1  1 = shutdown mode (display dark)
MOSI  output  1  serial data, MSB first
CS  output  1  chip select, active-low
clk_SPI  output  1  SPI clock, idle low
busy  output  1  high while INIT or a frame is in progress

Behaviour:
- Reset values, applied immediately on res with no clock needed: CS=1, clk_SPI=0, MOSI=0, busy=0, FSM=INIT, word index=0.
- Word format: 16 bits = {8'h0X address, 8-bit data}, shifted MSB first. SPI mode 0: MOSI changes only while clk_SPI is low; the slave samples on the rising edge.
- Word timing, with D=SCLK_DIV and CS falling at cycle t:
  - For bit k (0..15): MOSI is valid from t+2kD; clk_SPI rises at t+2kD+D and falls at t+2(k+1)D.
  - CS rises at t+32D and stays high for 2D cycles.
  - Word period is 34D clocks; the next word's CS falls immediately after.
- FSM states: INIT → IDLE ↔ FRAME. SHIFT and GAP are sub-phases inside both INIT and FRAME.
- INIT runs automatically on the first clock after res deasserts. busy=1. It sends five words:
  1. 0x09, data = (1<<NUM_DIGITS)-1 (code-B decode on used digits)
  2. 0x0B, data = NUM_DIGITS-1 (scan limit)
  3. 0x0F, data = 0x00 (display test off)
  4. 0x0A, data = {4'h0, intensity}
  5. 0x0C, data = {7'h0, ~blank}
- After INIT the FSM enters IDLE, where busy=0 and CS=1.
- IDLE → FRAME when ena=1. On that same cycle, snapshot digits, dp, intensity and blank into internal registers.
- FRAME sends 2+NUM_DIGITS words, all from the snapshot:
  - 0x0A, data = {4'h0, intensity}
  - 0x0C, data = {7'h0, ~blank}
  - for i = 0..NUM_DIGITS-1: address i+1, data = {dp[i], 3'b000, digits[i]}
- Input changes during a frame have no effect until the next snapshot.
- End of frame (end of the last word's CS-high gap):
  - ena=1: take a new snapshot and start the next frame back-to-back. busy stays 1 with no idle cycle.
  - ena=0: go to IDLE; busy falls.
- ena falling mid-frame: the current frame completes unchanged.
- BCD values 0xA..0xF pass through untouched; the chip's code-B decode handles them.
- res asserted mid-word: CS, clk_SPI and MOSI go to reset values immediately. The partial word is abandoned, and the full INIT replays after release.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
1. NUM_DIGITS=6, D=1, intensity=8, blank=0; release res → exactly five words 0x093F, 0x0B05, 0x0F00, 0x0A08, 0x0C01. Each has CS low for 32 clocks then high for 2 clocks. busy falls 170 clocks after release.
2. digits=24'h123456, dp=6'b000100, ena pulsed 1 cycle in IDLE → one frame of 0x0A08, 0x0C01, 0x0106, 0x0205, 0x0384, 0x0403, 0x0502, 0x0601. busy is high 272 clocks, then CS stays high.
3. ena held 1; change digits to 24'h000000 during the third word → current frame still sends 0x0384; the next frame, starting with no idle gap, sends 0x0100..0x0600.
4. blank=1 at snapshot → second frame word is 0x0C00. Deassert blank → the following frame sends 0x0C01.
5. Assert res while bit 7 of a digit word is shifting → CS=1 and clk_SPI=0 in the same cycle, with no clock edge needed. After release the INIT word 0x093F reappears before any digit word.
6. SCLK_DIV=3, NUM_DIGITS=4 → clk_SPI high and low for 3 clocks each, word period 102 clocks. INIT sends 0x090F and 0x0B03; a frame is 6 words.
